// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared FSM state type and byte width for wide_add_seq
package wide_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - 8-bit ripple-carry adder, the only adder in the datapath
module rca (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Co
);

  logic [8:0] c;

  // Chain of full adders, carry rippling from bit 0 upward
  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int i = 0; i < 8; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Co = c[8];
  end

endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - byte-serial wide adder; optional ovf output via WIDE_ADD_SEQ_OVF_EN
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef WIDE_ADD_SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic         busy
);

  // One index bit is kept even for a single-byte adder so the counter always exists.
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef logic [NBYTES-1:0][BYTE_W-1:0] bytes_t;

  state_e           state_q, state_d;
  bytes_t           a_q, a_d;
  bytes_t           b_q, b_d;
  bytes_t           sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W-1:0] add_s;
  logic              add_co;

  assign add_a = a_q[idx_q];
  assign add_b = b_q[idx_q];

  rca u_rca (
    .A   (add_a),
    .B   (add_b),
    .Cin (carry_q),
    .S   (add_s),
    .Co  (add_co)
  );

  // Next-state: latch on accept, one byte per RUN cycle, wait for consumer in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
`ifdef WIDE_ADD_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        sum_d[idx_q] = add_s;
        carry_d      = add_co;
        if (idx_q == LAST_IDX) begin
          // Index parks on the top byte rather than wrapping.
          state_d = DONE;
`ifdef WIDE_ADD_SEQ_OVF_EN
          // Carry into the MSB is recovered from the sum bit: a7 ^ b7 ^ s7.
          ovf_d   = add_a[BYTE_W-1] ^ add_b[BYTE_W-1] ^ add_s[BYTE_W-1] ^ add_co;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear; reset discards any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq (4-byte and 1-byte instances)
module tb_wide_add_seq;

  localparam int NB = 4;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [31:0] a, b, sum;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
  logic [7:0]  a1, b1, sum1;

`ifdef WIDE_ADD_SEQ_OVF_EN
  logic        ovf, ovf1;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  wide_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef WIDE_ADD_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  wide_add_seq #(.NBYTES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
`ifdef WIDE_ADD_SEQ_OVF_EN
    .ovf       (ovf1),
`endif
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation on the 4-byte instance; starts and ends at a negedge in IDLE.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                        output logic [31:0] gs, output logic gc, output logic go, output int lat);
    a = oa; b = ob; cin = oc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = ~oc;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    gs = sum; gc = cout;
`ifdef WIDE_ADD_SEQ_OVF_EN
    go = ovf;
`else
    go = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op1(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                         output logic [7:0] gs, output logic gc, output logic go, output int lat);
    a1 = oa; b1 = ob; cin1 = oc; in_valid1 = 1'b1; out_ready1 = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid1 = 1'b0; a1 = 8'h5A; b1 = 8'hC3; cin1 = ~oc;
    while (!out_valid1 && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    gs = sum1; gc = cout1;
`ifdef WIDE_ADD_SEQ_OVF_EN
    go = ovf1;
`else
    go = 1'b0;
`endif
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] gs, ra, rb;
    logic [7:0]  gs1;
    logic        gc, go, rc, exp_ovf;
    logic [32:0] exp33;
    int          lat, cyc;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef WIDE_ADD_SEQ_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    // Directed table, first accept directly on the first edge after reset release
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, gs, gc, go, lat);
      check($sformatf("vec%0d_sum", i), {gc, gs}, {vecs[i].co, vecs[i].s});
      check($sformatf("vec%0d_latency", i), lat, NB + 1);
    end

    // Hold in DONE with out_ready low; in_valid pulses must be ignored
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      in_valid = cyc[0]; a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; cin = 1'b1;
      check("run_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      check("hold_out_valid", out_valid, 1);
      check("hold_result", {cout, sum}, {1'b0, 32'h2345_6789});
      check("hold_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    // Handshake edge with in_valid still high: no same-edge accept
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("post_hs_busy", busy, 0);
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("post_hs_sum_hold", {cout, sum}, {1'b0, 32'h2345_6789});

    // Reset during the second RUN cycle
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_cout", cout, 0);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_rst_out_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, gs, gc, go, lat);
    check("after_rst_sum", {gc, gs}, 33'h0_0000_0008);
    check("after_rst_latency", lat, NB + 1);

`ifdef WIDE_ADD_SEQ_OVF_EN
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, gs, gc, go, lat);
    check("ovf_pos", go, 1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, gs, gc, go, lat);
    check("ovf_wrap", go, 0);
`endif

    // Single-byte instance: exactly one RUN cycle
    run_op1(8'h80, 8'h80, 1'b0, gs1, gc, go, lat);
    check("nb1_sum", {gc, gs1}, 9'h100);
    check("nb1_latency", lat, 2);
`ifdef WIDE_ADD_SEQ_OVF_EN
    check("nb1_ovf", go, 1);
`endif
    run_op1(8'h7F, 8'h01, 1'b1, gs1, gc, go, lat);
    check("nb1_sum_b", {gc, gs1}, 9'h081);
`ifdef WIDE_ADD_SEQ_OVF_EN
    check("nb1_ovf_b", go, 1);
`endif

    // Back-to-back random operations against an arithmetic reference
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      exp33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      exp_ovf = (ra[31] == rb[31]) && (exp33[31] != ra[31]);
      a = ra; b = rb; cin = rc;
      @(posedge clk);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        a = $urandom; b = $urandom; cin = ~rc;
      end while (!out_valid && cyc < 20);
      check("rand_latency", cyc, NB + 1);
      check("rand_result", {cout, sum}, exp33);
`ifdef WIDE_ADD_SEQ_OVF_EN
      check("rand_ovf", ovf, exp_ovf);
`else
      if (exp_ovf === 1'bx) check("rand_model", exp_ovf, 0);
`endif
      @(negedge clk);
      check("rand_period_ready", in_ready, 1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
